aon_adc_seq: RTL and testbench

//   Sequences the shared AON SAR ADC: power-up, settle wait, start-of-conversion, end-of-conversion capture.

---
 rtl/aon_adc_seq.sv | 204 ++++++++++++++++++++
 tb/tb_aon_adc_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aon_adc_seq.sv
// Sequencer for the shared always-on SAR ADC. It powers the ADC up, waits for it to settle,
// starts a conversion and captures the result. Baseband requests have fixed priority over software requests.
module aon_adc_seq #(
    parameter int unsigned DW       = 12,
    parameter int unsigned CNT_W    = 8,
    parameter bit          KEEP_PWR = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_bb_req,
    input  logic             i_sw_req,
    input  logic [CNT_W-1:0] i_settle_cnt,
    input  logic [CNT_W-1:0] i_conv_timeout,
    input  logic             i_err_clr,
    output logic             o_adc_pwr_en,
    output logic             o_adc_soc,
    input  logic             i_adc_eoc,
    input  logic [DW-1:0]    i_adc_dout,
    output logic [DW-1:0]    o_bb_data,
    output logic             o_bb_vld,
    output logic [DW-1:0]    o_sw_data,
    output logic             o_sw_vld,
    output logic             o_busy,
    output logic             o_timeout_err,
    output logic             o_bb_ovr,
    output logic             o_sw_ovr
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PWRUP = 3'd1;
    localparam logic [2:0] ST_SOC   = 3'd2;
    localparam logic [2:0] ST_CONV  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bb_pend_q, bb_pend_d;
    logic             sw_pend_q, sw_pend_d;
    logic             grant_sw_q, grant_sw_d;
    logic             pwr_up_q, pwr_up_d;
    logic [DW-1:0]    bb_data_q, bb_data_d;
    logic [DW-1:0]    sw_data_q, sw_data_d;
    logic             timeout_err_q, timeout_err_d;
    logic             bb_ovr_q, bb_ovr_d;
    logic             sw_ovr_q, sw_ovr_d;

    logic st_idle, st_soc, st_conv, st_done;
    logic cnt_zero;
    logic grant, grant_bb, grant_sw;
    logic eoc_hit, timeout_hit;
    logic bb_ovr_set, sw_ovr_set;

    assign st_idle  = (state_q == ST_IDLE);
    assign st_soc   = (state_q == ST_SOC);
    assign st_conv  = (state_q == ST_CONV);
    assign st_done  = (state_q == ST_DONE);
    assign cnt_zero = (cnt_q == '0);

    assign grant    = i_en & st_idle & (bb_pend_q | sw_pend_q);
    assign grant_bb = grant & bb_pend_q;
    assign grant_sw = grant & ~bb_pend_q;

    // eoc takes precedence over an expiring timeout in the same cycle.
    assign eoc_hit     = i_en & st_conv & i_adc_eoc;
    assign timeout_hit = i_en & st_conv & ~i_adc_eoc & cnt_zero;

    // A request is dropped only if its own pend is set and is not being granted this cycle.
    assign bb_ovr_set = i_en & i_bb_req & bb_pend_q & ~grant_bb;
    assign sw_ovr_set = i_en & i_sw_req & sw_pend_q & ~grant_sw;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_sw_d = grant_sw_q;
        pwr_up_d   = pwr_up_q;

        if (!i_en) begin
            state_d  = ST_IDLE;
            pwr_up_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (KEEP_PWR == 1'b0) begin
                        pwr_up_d = 1'b0;
                    end
                    if (grant) begin
                        grant_sw_d = grant_sw;
                        if (pwr_up_q) begin
                            state_d = ST_SOC;
                        end else begin
                            state_d = ST_PWRUP;
                            cnt_d   = i_settle_cnt;
                        end
                    end
                end
                ST_PWRUP: begin
                    pwr_up_d = 1'b1;
                    if (cnt_zero) begin
                        state_d = ST_SOC;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_SOC: begin
                    cnt_d   = i_conv_timeout;
                    state_d = ST_CONV;
                end
                ST_CONV: begin
                    if (eoc_hit) begin
                        state_d = ST_DONE;
                    end else if (timeout_hit) begin
                        state_d = ST_IDLE;
                        if (KEEP_PWR == 1'b0) begin
                            pwr_up_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    if (KEEP_PWR == 1'b0) begin
                        pwr_up_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bb_pend_d = 1'b0;
        sw_pend_d = 1'b0;
        if (i_en) begin
            bb_pend_d = (bb_pend_q & ~grant_bb) | i_bb_req;
            sw_pend_d = (sw_pend_q & ~grant_sw) | i_sw_req;
        end
    end

    always_comb begin
        bb_data_d = bb_data_q;
        sw_data_d = sw_data_q;
        if (eoc_hit) begin
            if (grant_sw_q) begin
                sw_data_d = i_adc_dout;
            end else begin
                bb_data_d = i_adc_dout;
            end
        end
    end

    // Setting a sticky flag takes precedence over clearing it in the same cycle.
    assign timeout_err_d = timeout_hit | (timeout_err_q & ~i_err_clr);
    assign bb_ovr_d      = bb_ovr_set  | (bb_ovr_q & ~i_err_clr);
    assign sw_ovr_d      = sw_ovr_set  | (sw_ovr_q & ~i_err_clr);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bb_pend_q     <= 1'b0;
            sw_pend_q     <= 1'b0;
            grant_sw_q    <= 1'b0;
            pwr_up_q      <= 1'b0;
            bb_data_q     <= '0;
            sw_data_q     <= '0;
            timeout_err_q <= 1'b0;
            bb_ovr_q      <= 1'b0;
            sw_ovr_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bb_pend_q     <= bb_pend_d;
            sw_pend_q     <= sw_pend_d;
            grant_sw_q    <= grant_sw_d;
            pwr_up_q      <= pwr_up_d;
            bb_data_q     <= bb_data_d;
            sw_data_q     <= sw_data_d;
            timeout_err_q <= timeout_err_d;
            bb_ovr_q      <= bb_ovr_d;
            sw_ovr_q      <= sw_ovr_d;
        end
    end

    // The power enable is decoded from state, so an async reset drops it without waiting for a clock edge.
    assign o_adc_pwr_en  = ~st_idle | (KEEP_PWR && pwr_up_q);
    assign o_adc_soc     = i_en & st_soc;
    assign o_bb_vld      = i_en & st_done & ~grant_sw_q;
    assign o_sw_vld      = i_en & st_done & grant_sw_q;
    assign o_bb_data     = bb_data_q;
    assign o_sw_data     = sw_data_q;
    assign o_busy        = ~st_idle;
    assign o_timeout_err = timeout_err_q;
    assign o_bb_ovr      = bb_ovr_q;
    assign o_sw_ovr      = sw_ovr_q;

endmodule

// File: tb/tb_aon_adc_seq.sv
// Directed bench for aon_adc_seq: u_dut0 uses KEEP_PWR=0 and u_dut1 uses KEEP_PWR=1.
// Each instance has its own enable, so only one of them is active in each scenario.
module tb_aon_adc_seq;

    logic        clk;
    logic        rst;
    logic        en0, en1;
    logic        bb_req, sw_req;
    logic [7:0]  settle, timeout;
    logic        err_clr;
    logic        eoc;
    logic [11:0] dout;

    logic        pwr0, soc0, bbv0, swv0, busy0, terr0, bbo0, swo0;
    logic [11:0] bbd0, swd0;
    logic        pwr1, soc1, bbv1, swv1, busy1, terr1, bbo1, swo1;
    logic [11:0] bbd1, swd1;

    int n_vec = 0;
    int n_err = 0;

    aon_adc_seq #(.DW(12), .CNT_W(8), .KEEP_PWR(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en0), .i_bb_req(bb_req), .i_sw_req(sw_req),
        .i_settle_cnt(settle), .i_conv_timeout(timeout), .i_err_clr(err_clr),
        .o_adc_pwr_en(pwr0), .o_adc_soc(soc0), .i_adc_eoc(eoc), .i_adc_dout(dout),
        .o_bb_data(bbd0), .o_bb_vld(bbv0), .o_sw_data(swd0), .o_sw_vld(swv0),
        .o_busy(busy0), .o_timeout_err(terr0), .o_bb_ovr(bbo0), .o_sw_ovr(swo0)
    );

    aon_adc_seq #(.DW(12), .CNT_W(8), .KEEP_PWR(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en1), .i_bb_req(bb_req), .i_sw_req(sw_req),
        .i_settle_cnt(settle), .i_conv_timeout(timeout), .i_err_clr(err_clr),
        .o_adc_pwr_en(pwr1), .o_adc_soc(soc1), .i_adc_eoc(eoc), .i_adc_dout(dout),
        .o_bb_data(bbd1), .o_bb_vld(bbv1), .o_sw_data(swd1), .o_sw_vld(swv1),
        .o_busy(busy1), .o_timeout_err(terr1), .o_bb_ovr(bbo1), .o_sw_ovr(swo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; bb_req = 1'b0; sw_req = 1'b0;
        settle = 8'd3; timeout = 8'd10; err_clr = 1'b0; eoc = 1'b0; dout = 12'h000;

        // Reset values
        step(1);
        check("rst_pwr", pwr0, 0);
        check("rst_busy", busy0, 0);
        check("rst_soc", soc0, 0);
        check("rst_bbd", bbd0, 0);
        check("rst_swd", swd0, 0);
        check("rst_terr", terr0, 0);
        check("rst_k_pwr", pwr1, 0);
        rst = 1'b0; en0 = 1'b1;
        step(1);

        // Single bb conversion: S=3, eoc two cycles after soc, dout 0xABC
        bb_req = 1'b1;
        step(1);
        check("t1_pend_busy", busy0, 0);
        bb_req = 1'b0;
        step(1);
        check("t1_pwrup_pwr", pwr0, 1);
        check("t1_pwrup_busy", busy0, 1);
        check("t1_pwrup_soc", soc0, 0);
        step(3);
        check("t1_pwrup_last_soc", soc0, 0);
        step(1);
        check("t1_soc", soc0, 1);
        step(1);
        check("t1_soc_once", soc0, 0);
        step(1);
        check("t1_no_vld_early", bbv0, 0);
        eoc = 1'b1; dout = 12'hABC;
        step(1);
        check("t1_bb_vld", bbv0, 1);
        check("t1_bb_data", bbd0, 12'hABC);
        check("t1_sw_vld", swv0, 0);
        eoc = 1'b0; dout = 12'h000;
        step(1);
        check("t1_vld_once", bbv0, 0);
        check("t1_idle_busy", busy0, 0);
        check("t1_idle_pwr", pwr0, 0);
        check("t1_data_held", bbd0, 12'hABC);

        // Simultaneous bb and sw requests: bb served first
        bb_req = 1'b1; sw_req = 1'b1;
        step(1);
        bb_req = 1'b0; sw_req = 1'b0;
        step(1);
        check("t2_busy", busy0, 1);
        step(4);
        check("t2_soc_a", soc0, 1);
        step(1);
        eoc = 1'b1; dout = 12'h111;
        step(1);
        check("t2_bb_vld", bbv0, 1);
        check("t2_bb_data", bbd0, 12'h111);
        check("t2_sw_vld_a", swv0, 0);
        eoc = 1'b0;
        step(1);
        check("t2_gap_busy", busy0, 0);
        check("t2_gap_pwr", pwr0, 0);
        step(1);
        check("t2_sw_pwrup", busy0, 1);
        step(4);
        check("t2_soc_b", soc0, 1);
        step(1);
        eoc = 1'b1; dout = 12'h222;
        step(1);
        check("t2_sw_vld", swv0, 1);
        check("t2_sw_data", swd0, 12'h222);
        check("t2_bb_vld_b", bbv0, 0);
        check("t2_bb_kept", bbd0, 12'h111);
        eoc = 1'b0;
        step(1);
        check("t2_idle", busy0, 0);
        check("t2_bb_ovr", bbo0, 0);
        check("t2_sw_ovr", swo0, 0);

        // Timeout with T=4: five CONV cycles, then error and IDLE
        timeout = 8'd4; bb_req = 1'b1;
        step(1);
        bb_req = 1'b0;
        step(1);
        step(4);
        check("t3_soc", soc0, 1);
        step(1);
        check("t3_conv1", busy0, 1);
        step(4);
        check("t3_conv5_busy", busy0, 1);
        check("t3_conv5_err", terr0, 0);
        step(1);
        check("t3_to_idle", busy0, 0);
        check("t3_err", terr0, 1);
        check("t3_no_vld", bbv0, 0);
        check("t3_data_kept", bbd0, 12'h111);
        err_clr = 1'b1; timeout = 8'd10;
        step(1);
        check("t3_err_clr", terr0, 0);
        err_clr = 1'b0;

        // Two bb requests during CONV: second overflows, one extra conversion
        bb_req = 1'b1;
        step(1);
        bb_req = 1'b0;
        step(1);
        step(4);
        check("t4_soc_a", soc0, 1);
        step(1);
        bb_req = 1'b1;
        step(1);
        check("t4_first_no_ovr", bbo0, 0);
        bb_req = 1'b0;
        step(1);
        bb_req = 1'b1;
        step(1);
        check("t4_second_ovr", bbo0, 1);
        bb_req = 1'b0; eoc = 1'b1; dout = 12'h5A5;
        step(1);
        check("t4_vld_a", bbv0, 1);
        check("t4_data_a", bbd0, 12'h5A5);
        eoc = 1'b0;
        step(1);
        check("t4_gap", busy0, 0);
        step(1);
        check("t4_extra_pwrup", busy0, 1);
        step(4);
        check("t4_soc_b", soc0, 1);
        step(1);
        eoc = 1'b1; dout = 12'h3C3;
        step(1);
        check("t4_vld_b", bbv0, 1);
        check("t4_data_b", bbd0, 12'h3C3);
        eoc = 1'b0;
        step(4);
        check("t4_no_third", busy0, 0);
        check("t4_pwr_off", pwr0, 0);
        check("t4_ovr_sticky", bbo0, 1);

        // Enable dropped during PWRUP with a pending sw request
        sw_req = 1'b1; err_clr = 1'b1;
        step(1);
        check("t6_ovr_cleared", bbo0, 0);
        sw_req = 1'b0; err_clr = 1'b0;
        step(1);
        check("t6_pwrup_busy", busy0, 1);
        check("t6_pwrup_pwr", pwr0, 1);
        en0 = 1'b0;
        step(1);
        check("t6_abort_busy", busy0, 0);
        check("t6_abort_pwr", pwr0, 0);
        check("t6_abort_soc", soc0, 0);
        en0 = 1'b1;
        step(6);
        check("t6_pend_gone", busy0, 0);
        check("t6_no_soc", soc0, 0);
        check("t6_no_vld", swv0, 0);
        check("t6_sw_ovr", swo0, 0);

        // KEEP_PWR=1 instance: back-to-back bb requests skip PWRUP the second time
        en0 = 1'b0; en1 = 1'b1; bb_req = 1'b1;
        step(1);
        bb_req = 1'b0;
        step(1);
        check("t5_pwrup_busy", busy1, 1);
        step(4);
        check("t5_soc_a", soc1, 1);
        step(1);
        eoc = 1'b1; dout = 12'h7E7;
        step(1);
        check("t5_vld_a", bbv1, 1);
        check("t5_data_a", bbd1, 12'h7E7);
        eoc = 1'b0; bb_req = 1'b1;
        step(1);
        check("t5_gap_pwr", pwr1, 1);
        check("t5_gap_busy", busy1, 0);
        bb_req = 1'b0;
        step(1);
        check("t5_soc_b_direct", soc1, 1);
        check("t5_soc_b_pwr", pwr1, 1);
        step(1);
        eoc = 1'b1; dout = 12'h0F0;
        step(1);
        check("t5_vld_b", bbv1, 1);
        check("t5_data_b", bbd1, 12'h0F0);
        eoc = 1'b0;
        step(1);
        check("t5_idle_busy", busy1, 0);
        check("t5_idle_pwr_kept", pwr1, 1);
        check("t5_dut0_quiet", busy0, 0);
        en1 = 1'b0;
        step(1);
        check("t5_en_off_pwr", pwr1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
